// File: rtl/single_cycle.sv
// Single-cycle RV32I core: instruction ROM, data RAM and memory-mapped board IO.
// Define IO_HEX_DECODE_EN to store hex nibbles and drive decoded 7-segment glyphs instead of raw segments.
module single_cycle #(
  parameter string       IMEM_FILE  = "imem.hex",
  parameter int unsigned IMEM_DEPTH = 2048,
  parameter int unsigned DMEM_DEPTH = 2048,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [16:0] i_io_sw,
  output logic [11:0] o_io_lcd,
  output logic [7:0]  o_io_ledg,
  output logic [16:0] o_io_ledr,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] pc_debug,
  output logic [31:0] instruc_test,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] alu_data,
  output logic [31:0] ld_data,
  output logic [31:0] wb_data,
  output logic [31:0] r25,
  output logic [31:0] r26
);
  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);
`ifdef IO_HEX_DECODE_EN
  localparam int unsigned HEX_W = 4;
`else
  localparam int unsigned HEX_W = 7;
`endif
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33;

  logic [31:0]      imem [IMEM_DEPTH];
  logic [31:0]      dmem [DMEM_DEPTH];
  logic [31:0]      regs_q [32];
  logic [31:0]      pc_q, pc_d, pc_plus4;
  logic [16:0]      ledr_q;
  logic [7:0]       ledg_q;
  logic [11:0]      lcd_q;
  logic [HEX_W-1:0] hex_q [8];

  logic [31:0] instr, imm, imm_i, imm_s, imm_b, imm_u, imm_j, op_a, op_b;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3, alu_f3;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_imm, is_op;
  logic        alu_sub, br_cond, rf_we;

  assign instr    = imem[pc_q[IAW+1:2]];
  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign f3       = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign is_lui   = (opcode == OP_LUI);
  assign is_auipc = (opcode == OP_AUIPC);
  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign is_br    = (opcode == OP_BR);
  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign is_imm   = (opcode == OP_IMM);
  assign is_op    = (opcode == OP_REG);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    imm = imm_i;
    case (opcode)
      OP_ST:            imm = imm_s;
      OP_BR:            imm = imm_b;
      OP_LUI, OP_AUIPC: imm = imm_u;
      OP_JAL:           imm = imm_j;
      default:          ;
    endcase
  end

  assign rs1_data = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
  assign rs2_data = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];

  // ALU also forms branch/jump targets and load/store addresses.
  assign op_a    = (is_auipc || is_jal || is_br) ? pc_q : (is_lui ? 32'd0 : rs1_data);
  assign op_b    = is_op ? rs2_data : imm;
  assign alu_f3  = (is_op || is_imm) ? f3 : 3'b000;
  assign alu_sub = is_op && instr[30];

  always_comb begin
    case (alu_f3)
      3'b000:  alu_data = alu_sub ? op_a - op_b : op_a + op_b;
      3'b001:  alu_data = op_a << op_b[4:0];
      3'b010:  alu_data = {31'd0, $signed(op_a) < $signed(op_b)};
      3'b011:  alu_data = {31'd0, op_a < op_b};
      3'b100:  alu_data = op_a ^ op_b;
      3'b101:  alu_data = instr[30] ? 32'($signed(op_a) >>> op_b[4:0]) : op_a >> op_b[4:0];
      3'b110:  alu_data = op_a | op_b;
      default: alu_data = op_a & op_b;
    endcase
  end

  always_comb begin
    case (f3)
      3'b000:  br_cond = (rs1_data == rs2_data);
      3'b001:  br_cond = (rs1_data != rs2_data);
      3'b100:  br_cond = ($signed(rs1_data) < $signed(rs2_data));
      3'b101:  br_cond = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  br_cond = (rs1_data < rs2_data);
      3'b111:  br_cond = (rs1_data >= rs2_data);
      default: br_cond = 1'b0;
    endcase
  end

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_d     = (is_jal || (is_br && br_cond)) ? alu_data :
                    is_jalr ? (alu_data & ~32'd1) : pc_plus4;

  logic [31:0] addr, rd_word, st_data, st_mask, st_word;
  logic [3:0]  st_be;
  logic        is_ram;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign addr   = alu_data;
  assign is_ram = (addr[15:13] == 3'b000);

  // Word read shared by loads and by the read-modify-write of IO registers.
  always_comb begin
    rd_word = 32'd0;
    if (is_ram) rd_word = dmem[addr[DAW+1:2]];
    else begin
      case (addr[15:2])
        14'h1C00: rd_word = {15'd0, ledr_q};
        14'h1C04: rd_word = {24'd0, ledg_q};
        14'h1C08: rd_word = {8'(hex_q[3]), 8'(hex_q[2]), 8'(hex_q[1]), 8'(hex_q[0])};
        14'h1C09: rd_word = {8'(hex_q[7]), 8'(hex_q[6]), 8'(hex_q[5]), 8'(hex_q[4])};
        14'h1C0C: rd_word = {20'd0, lcd_q};
        14'h1E00: rd_word = {15'd0, i_io_sw};
        default:  rd_word = 32'd0;
      endcase
    end
  end

  always_comb begin
    st_data = rs2_data;
    st_be   = 4'b1111;
    case (f3[1:0])
      2'b00: begin st_data = {4{rs2_data[7:0]}};  st_be = 4'b0001 << addr[1:0]; end
      2'b01: begin st_data = {2{rs2_data[15:0]}}; st_be = addr[1] ? 4'b1100 : 4'b0011; end
      default: ;
    endcase
  end

  assign st_mask = {{8{st_be[3]}}, {8{st_be[2]}}, {8{st_be[1]}}, {8{st_be[0]}}};
  assign st_word = (rd_word & ~st_mask) | (st_data & st_mask);

  always_comb begin
    case (addr[1:0])
      2'd0:    ld_b = rd_word[7:0];
      2'd1:    ld_b = rd_word[15:8];
      2'd2:    ld_b = rd_word[23:16];
      default: ld_b = rd_word[31:24];
    endcase
  end
  assign ld_h = addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = 32'd0;
    if (is_ld) begin
      case (f3)
        3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
        3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
        3'b100:  ld_data = {24'd0, ld_b};
        3'b101:  ld_data = {16'd0, ld_h};
        default: ld_data = rd_word;
      endcase
    end
  end

  assign rf_we = (is_lui || is_auipc || is_jal || is_jalr || is_ld || is_imm || is_op) && (rd != 5'd0);

  always_comb begin
    wb_data = alu_data;
    if (rf_we) begin
      case (opcode)
        OP_LUI:          wb_data = imm;
        OP_JAL, OP_JALR: wb_data = pc_plus4;
        OP_LD:           wb_data = ld_data;
        default:         ;
      endcase
    end
  end

  // Architectural state; reset overrides any write of the current instruction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q   <= RESET_PC;
      ledr_q <= '0;
      ledg_q <= '0;
      lcd_q  <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      for (int i = 0; i < 8; i++)  hex_q[i]  <= '0;
    end else begin
      pc_q <= pc_d;
      if (rf_we) regs_q[rd] <= wb_data;
      if (is_st && !is_ram) begin
        case (addr[15:2])
          14'h1C00: ledr_q <= st_word[16:0];
          14'h1C04: ledg_q <= st_word[7:0];
          14'h1C08: for (int i = 0; i < 4; i++) hex_q[i] <= st_word[8*i +: HEX_W];
          14'h1C09: for (int i = 0; i < 4; i++) hex_q[i+4] <= st_word[8*i +: HEX_W];
          14'h1C0C: lcd_q <= st_word[11:0];
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && is_st && is_ram)
      for (int b = 0; b < 4; b++)
        if (st_be[b]) dmem[addr[DAW+1:2]][8*b +: 8] <= st_data[8*b +: 8];
  end

`ifdef IO_HEX_DECODE_EN
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
    endcase
  endfunction
  assign o_io_hex0 = seg7(hex_q[0]);
  assign o_io_hex1 = seg7(hex_q[1]);
  assign o_io_hex2 = seg7(hex_q[2]);
  assign o_io_hex3 = seg7(hex_q[3]);
  assign o_io_hex4 = seg7(hex_q[4]);
  assign o_io_hex5 = seg7(hex_q[5]);
  assign o_io_hex6 = seg7(hex_q[6]);
  assign o_io_hex7 = seg7(hex_q[7]);
`else
  assign o_io_hex0 = hex_q[0];
  assign o_io_hex1 = hex_q[1];
  assign o_io_hex2 = hex_q[2];
  assign o_io_hex3 = hex_q[3];
  assign o_io_hex4 = hex_q[4];
  assign o_io_hex5 = hex_q[5];
  assign o_io_hex6 = hex_q[6];
  assign o_io_hex7 = hex_q[7];
`endif

  assign o_io_ledr    = ledr_q;
  assign o_io_ledg    = ledg_q;
  assign o_io_lcd     = lcd_q;
  assign pc_debug     = pc_q;
  assign instruc_test = instr;
  assign r25          = regs_q[25];
  assign r26          = regs_q[26];

  logic unused_bits;
  assign unused_bits = ^{pc_q, addr, st_word};
endmodule

// File: tb/tb_single_cycle.sv
// Directed bench for single_cycle: programs are placed in the ROM array, then stepped one instruction per clock.
module tb_single_cycle;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [16:0] i_io_sw = '0;
  logic [11:0] o_io_lcd;
  logic [7:0]  o_io_ledg;
  logic [16:0] o_io_ledr;
  logic [6:0]  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3, o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7;
  logic [31:0] pc_debug, instruc_test, rs1_data, rs2_data, alu_data, ld_data, wb_data, r25, r26;

  int checks = 0;
  int errors = 0;
  logic [31:0] prog [16];

`ifdef IO_HEX_DECODE_EN
  localparam logic [31:0] HEX_RST = 32'h40, HEX_F = 32'h0E, HEX_RB = 32'h0F;
`else
  localparam logic [31:0] HEX_RST = 32'h00, HEX_F = 32'h7F, HEX_RB = 32'h7F;
`endif

  single_cycle #(.IMEM_FILE("")) dut (
    .clk_i(clk_i), .rst_i(rst_i), .i_io_sw(i_io_sw),
    .o_io_lcd(o_io_lcd), .o_io_ledg(o_io_ledg), .o_io_ledr(o_io_ledr),
    .o_io_hex0(o_io_hex0), .o_io_hex1(o_io_hex1), .o_io_hex2(o_io_hex2), .o_io_hex3(o_io_hex3),
    .o_io_hex4(o_io_hex4), .o_io_hex5(o_io_hex5), .o_io_hex6(o_io_hex6), .o_io_hex7(o_io_hex7),
    .pc_debug(pc_debug), .instruc_test(instruc_test), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_data(alu_data), .ld_data(ld_data), .wb_data(wb_data), .r25(r25), .r26(r26)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic clear_prog();
    for (int k = 0; k < 16; k++) prog[k] = 32'h0000_0013;
  endtask

  // Hold reset while the new program is written, then release after two clocks.
  task automatic load_and_reset();
    rst_i = 1'b1;
    for (int k = 0; k < 16; k++) dut.imem[k] = prog[k];
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    // ALU and x0
    clear_prog();
    prog[0] = 32'h12300C93;  // addi x25,x0,0x123
    prog[1] = 32'hFFFC8D13;  // addi x26,x25,-1
    prog[2] = 32'h019C8033;  // add  x0,x25,x25
    prog[3] = 32'h00000033;  // add  x0,x0,x0
    load_and_reset();
    chk("rst_pc", pc_debug, 32'h0);
    chk("rst_r25", r25, 32'h0);
    chk("rst_r26", r26, 32'h0);
    chk("rst_ledr", {15'd0, o_io_ledr}, 32'h0);
    chk("rst_ledg", {24'd0, o_io_ledg}, 32'h0);
    chk("rst_lcd", {20'd0, o_io_lcd}, 32'h0);
    chk("rst_hex0", {25'd0, o_io_hex0}, HEX_RST);
    chk("rst_hex7", {25'd0, o_io_hex7}, HEX_RST);
    chk("addi_alu", alu_data, 32'h123);
    tick();
    chk("r25", r25, 32'h123);
    chk("addi_neg_alu", alu_data, 32'h122);
    tick();
    chk("r26", r26, 32'h122);
    chk("add_x0_alu", alu_data, 32'h246);
    chk("add_x0_wb", wb_data, 32'h246);
    tick();
    chk("x0_read", rs1_data, 32'h0);
    chk("pc_seq", pc_debug, 32'hC);

    // Switch load, IO writes and readback
    clear_prog();
    prog[0]  = 32'h000080B7;  // lui  x1,8
    prog[1]  = 32'h8000A103;  // lw   x2,-2048(x1)   -> 0x7800
    prog[2]  = 32'h000201B7;  // lui  x3,0x20
    prog[3]  = 32'hFFF18193;  // addi x3,x3,-1
    prog[4]  = 32'h00007237;  // lui  x4,7
    prog[5]  = 32'h00322023;  // sw   x3,0(x4)
    prog[6]  = 32'h00022283;  // lw   x5,0(x4)
    prog[7]  = 32'h8030A023;  // sw   x3,-2048(x1)   -> switches
    prog[8]  = 32'h8000A303;  // lw   x6,-2048(x1)
    prog[9]  = 32'h02320023;  // sb   x3,0x20(x4)    -> HEX0
    prog[10] = 32'h02022383;  // lw   x7,0x20(x4)
    i_io_sw = 17'h1A5A5;
    load_and_reset();
    tick();
    chk("sw_ld_alu", alu_data, 32'h7800);
    chk("sw_ld_data", ld_data, 32'h0001A5A5);
    chk("sw_ld_wb", wb_data, 32'h0001A5A5);
    repeat (4) tick();
    chk("st_pc", pc_debug, 32'h14);
    chk("st_alu", alu_data, 32'h7000);
    chk("st_ld_zero", ld_data, 32'h0);
    chk("ledr_before", {15'd0, o_io_ledr}, 32'h0);
    tick();
    chk("ledr_after", {15'd0, o_io_ledr}, 32'h1FFFF);
    chk("ledr_readback", ld_data, 32'h1FFFF);
    tick();
    tick();
    chk("sw_after_write", ld_data, 32'h0001A5A5);
    tick();
    tick();
    chk("hex0_out", {25'd0, o_io_hex0}, HEX_F);
    chk("hex1_out", {25'd0, o_io_hex1}, HEX_RST);
    chk("hex_readback", ld_data, HEX_RB);

    // Byte / halfword loads and stores
    clear_prog();
    prog[0] = 32'h000080B7;  // lui  x1,8
    prog[1] = 32'h0FF08093;  // addi x1,x1,255
    prog[2] = 32'h10101023;  // sh   x1,0x100(x0)
    prog[3] = 32'h10100103;  // lb   x2,0x101(x0)
    prog[4] = 32'h10104103;  // lbu  x2,0x101(x0)
    prog[5] = 32'h10001103;  // lh   x2,0x100(x0)
    prog[6] = 32'h10005103;  // lhu  x2,0x100(x0)
    load_and_reset();
    chk("rst_ledr_cleared", {15'd0, o_io_ledr}, 32'h0);
    repeat (3) tick();
    chk("lb_alu", alu_data, 32'h101);
    chk("lb", ld_data, 32'hFFFFFF80);
    chk("lb_wb", wb_data, 32'hFFFFFF80);
    tick();
    chk("lbu", ld_data, 32'h00000080);
    tick();
    chk("lh", ld_data, 32'hFFFF80FF);
    tick();
    chk("lhu", ld_data, 32'h000080FF);

    // Control flow
    clear_prog();
    prog[4] = 32'h00000463;  // 0x10 beq  x0,x0,+8
    prog[6] = 32'h00008463;  // 0x18 beq  x1,x0,+8
    prog[7] = 32'h00508067;  // 0x1C jalr x0,5(x1)
    prog[8] = 32'hFF1FF0EF;  // 0x20 jal  x1,-16
    load_and_reset();
    repeat (4) tick();
    chk("beq_pc", pc_debug, 32'h10);
    chk("beq_target", alu_data, 32'h18);
    tick();
    chk("beq_taken_pc", pc_debug, 32'h18);
    tick();
    chk("jal_pc", pc_debug, 32'h20);
    chk("jal_link", wb_data, 32'h24);
    tick();
    chk("jal_target_pc", pc_debug, 32'h10);
    tick();
    chk("x1_link", rs1_data, 32'h24);
    tick();
    chk("beq_not_taken_pc", pc_debug, 32'h1C);
    tick();
    chk("jalr_pc", pc_debug, 32'h28);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
